// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: a button pop picks a velocity from a free-running LFSR,
// and the sprite then moves once per video frame, bouncing off the screen edges.
module sprite_motion_ctrl #(
   parameter int          SCREEN_W   = 1280,
   parameter int          SCREEN_H   = 720,
   parameter int          SPRITE_W   = 64,
   parameter int          SPRITE_H   = 64,
   parameter int          POP_FRAMES = 30,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   input  logic        nf_in,
   input  logic        pop_in,
   input  logic        halt_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic        pop_out,
   output logic        moving_out,
   output logic [1:0]  state_dbg
);

   // Output contract: every output is a register. x_out/y_out change only on the
   // cycle after a sampled nf_in pulse, so they hold steady for the whole frame.

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MOVING  = 2'd1,
      POPPING = 2'd2
   } state_t;

   localparam int                 X_MAX    = SCREEN_W - SPRITE_W;
   localparam int                 Y_MAX    = SCREEN_H - SPRITE_H;
   localparam logic signed [12:0] X_LIM    = 13'(X_MAX);
   localparam logic signed [12:0] Y_LIM    = 13'(Y_MAX);
   localparam logic [15:0]        POP_INIT = 16'(POP_FRAMES);

   state_t             state, state_next;
   logic [15:0]        lfsr, lfsr_next;
   logic               pop_prev;
   logic               pop_edge;
   logic signed [4:0]  vx, vy, vx_next, vy_next;
   logic [10:0]        x_next;
   logic [9:0]         y_next;
   logic [15:0]        cnt, cnt_next;
   logic signed [12:0] xn, yn;

   // Magnitude 1..8 from the low three bits, sign from bit 3.
   function automatic logic signed [4:0] vel(input logic [3:0] f);
      logic signed [4:0] mag;
      mag = $signed({2'b00, f[2:0]}) + 5'sd1;
      return f[3] ? -mag : mag;
   endfunction

   assign pop_edge  = pop_in & ~pop_prev;
   assign state_dbg = state;

   always_comb begin
      lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (lfsr == 16'h0000) lfsr_next = LFSR_SEED;
   end

   assign xn = $signed({2'b00, x_out}) + $signed({{8{vx[4]}}, vx});
   assign yn = $signed({3'b000, y_out}) + $signed({{8{vy[4]}}, vy});

   always_comb begin
      state_next = state;
      vx_next    = vx;
      vy_next    = vy;
      x_next     = x_out;
      y_next     = y_out;
      cnt_next   = cnt;
      if (halt_in) begin
         state_next = IDLE;
         vx_next    = 5'sd0;
         vy_next    = 5'sd0;
         cnt_next   = 16'd0;
      end else if (pop_edge) begin
         state_next = POPPING;
         cnt_next   = POP_INIT;
         vx_next    = vel(lfsr[3:0]);
         vy_next    = vel(lfsr[7:4]);
      end else if (nf_in && state != IDLE) begin
         if (xn < 0) begin
            x_next  = 11'd0;
            vx_next = -vx;
         end else if (xn > X_LIM) begin
            x_next  = 11'(X_MAX);
            vx_next = -vx;
         end else begin
            x_next = xn[10:0];
         end
         if (yn < 0) begin
            y_next  = 10'd0;
            vy_next = -vy;
         end else if (yn > Y_LIM) begin
            y_next  = 10'(Y_MAX);
            vy_next = -vy;
         end else begin
            y_next = yn[9:0];
         end
         if (state == POPPING) begin
            if (cnt <= 16'd1) begin
               cnt_next   = 16'd0;
               state_next = MOVING;
            end else begin
               cnt_next = cnt - 16'd1;
            end
         end
      end
   end

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         state      <= IDLE;
         lfsr       <= LFSR_SEED;
         pop_prev   <= 1'b0;
         vx         <= 5'sd0;
         vy         <= 5'sd0;
         cnt        <= 16'd0;
         x_out      <= 11'd0;
         y_out      <= 10'd0;
         pop_out    <= 1'b0;
         moving_out <= 1'b0;
      end else begin
         state      <= state_next;
         lfsr       <= lfsr_next;
         pop_prev   <= pop_in;
         vx         <= vx_next;
         vy         <= vy_next;
         cnt        <= cnt_next;
         x_out      <= x_next;
         y_out      <= y_next;
         pop_out    <= (state_next == POPPING);
         moving_out <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: per-cycle scoreboard from a spec-level
// model plus hand-computed directed checks at the interesting frames.
module tb_sprite_motion_ctrl;

   localparam int          SCREEN_W   = 1280;
   localparam int          SCREEN_H   = 720;
   localparam int          SPRITE_W   = 64;
   localparam int          SPRITE_H   = 64;
   localparam int          POP_FRAMES = 30;
   localparam logic [15:0] SEED       = 16'hACE1;
   localparam int          WAIT_BOUND = 20000;
   localparam int          W          = 23;

   logic        clk = 1'b0;
   logic        rst_in = 1'b0, nf_in = 1'b0, pop_in = 1'b0, halt_in = 1'b0;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        pop_out, moving_out;
   logic [1:0]  state_dbg;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;

   logic rst_level = 1'b0, pop_level = 1'b0, halt_level = 1'b0;

   int          mx, my, mvx, mvy, mstate, mcnt;
   logic        mpop_prev;
   logic [15:0] mlfsr;

   sprite_motion_ctrl #(
      .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .SPRITE_W(SPRITE_W),
      .SPRITE_H(SPRITE_H), .POP_FRAMES(POP_FRAMES), .LFSR_SEED(SEED)
   ) dut (
      .pixel_clk_in(clk), .rst_in(rst_in), .nf_in(nf_in), .pop_in(pop_in),
      .halt_in(halt_in), .x_out(x_out), .y_out(y_out), .pop_out(pop_out),
      .moving_out(moving_out), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int vel(input logic [3:0] f);
      int mag;
      mag = int'(f[2:0]) + 1;
      return f[3] ? -mag : mag;
   endfunction

   // Monitor: outputs settle after the posedge, so compare on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         check("sb_outputs", int'({x_out, y_out, pop_out, moving_out}), int'(e));
      end
   end

   // One clock: apply inputs, advance the model, push the expected post-edge outputs.
   task automatic cycle(input logic nf);
      logic edge_m;
      int   nx, ny;
      rst_in  = rst_level;
      pop_in  = pop_level;
      halt_in = halt_level;
      nf_in   = nf;
      edge_m  = pop_level & ~mpop_prev;
      if (rst_level) begin
         mx = 0; my = 0; mvx = 0; mvy = 0; mstate = 0; mcnt = 0;
         mpop_prev = 1'b0;
         mlfsr = SEED;
      end else begin
         if (halt_level) begin
            mstate = 0; mvx = 0; mvy = 0; mcnt = 0;
         end else if (edge_m) begin
            mstate = 2; mcnt = POP_FRAMES;
            mvx = vel(mlfsr[3:0]);
            mvy = vel(mlfsr[7:4]);
         end else if (nf && mstate != 0) begin
            nx = mx + mvx;
            ny = my + mvy;
            if (nx < 0) begin mx = 0; mvx = -mvx; end
            else if (nx > SCREEN_W - SPRITE_W) begin mx = SCREEN_W - SPRITE_W; mvx = -mvx; end
            else mx = nx;
            if (ny < 0) begin my = 0; mvy = -mvy; end
            else if (ny > SCREEN_H - SPRITE_H) begin my = SCREEN_H - SPRITE_H; mvy = -mvy; end
            else my = ny;
            if (mstate == 2) begin
               mcnt = mcnt - 1;
               if (mcnt == 0) mstate = 1;
            end
         end
         mpop_prev = pop_level;
         if (mlfsr == 16'h0000) mlfsr = SEED;
         else mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
      end
      @(posedge clk);
      exp_q.push_back({11'(mx), 10'(my), (mstate == 2), (mstate != 0)});
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b1);
         cycle(1'b0);
      end
   endtask

   // Release the button, wait until the LFSR holds the wanted low byte, then press.
   task automatic do_pop(input logic [7:0] val, input logic nf);
      int n;
      pop_level = 1'b0;
      cycle(1'b0);
      n = 0;
      while (mlfsr[7:0] != val && n < WAIT_BOUND) begin
         cycle(1'b0);
         n++;
      end
      if (n >= WAIT_BOUND) begin
         checks++;
         failures++;
         $display("FAIL lfsr_wait: got %0h expected %0h", mlfsr[7:0], val);
      end
      pop_level = 1'b1;
      cycle(nf);
   endtask

   task automatic do_reset();
      rst_level = 1'b1;
      pop_level = 1'b0;
      halt_level = 1'b0;
      cycle(1'b0);
      rst_level = 1'b0;
   endtask

   initial begin
      rst_level = 1'b1;
      cycle(1'b0);
      cycle(1'b0);
      rst_level = 1'b0;
      check("reset_x", int'(x_out), 0);
      check("reset_state", int'(state_dbg), 0);

      // No pop: frames do nothing.
      frames(5);
      check("idle_x", int'(x_out), 0);
      check("idle_y", int'(y_out), 0);
      check("idle_moving", int'(moving_out), 0);

      // vx=+4, vy=+2.
      do_pop(8'h13, 1'b0);
      check("pop_rise", int'(pop_out), 1);
      check("moving_rise", int'(moving_out), 1);
      frames(3);
      check("b3_x", int'(x_out), 12);
      check("b3_y", int'(y_out), 6);
      frames(26);
      check("b29_pop", int'(pop_out), 1);
      frames(1);
      check("b30_pop", int'(pop_out), 0);
      check("b30_moving", int'(moving_out), 1);
      check("b30_x", int'(x_out), 120);
      check("b30_y", int'(y_out), 60);

      // Halt with a simultaneous pop edge while popping.
      do_pop(8'h13, 1'b0);
      frames(2);
      check("c_x", int'(x_out), 128);
      pop_level = 1'b0;
      cycle(1'b0);
      pop_level = 1'b1;
      halt_level = 1'b1;
      cycle(1'b0);
      halt_level = 1'b0;
      check("halt_pop", int'(pop_out), 0);
      check("halt_moving", int'(moving_out), 0);
      frames(3);
      check("halt_x", int'(x_out), 128);
      check("halt_y", int'(y_out), 64);
      do_pop(8'h13, 1'b0);
      frames(1);
      check("resume_x", int'(x_out), 132);
      check("resume_y", int'(y_out), 66);

      // Mid-operation reset.
      do_reset();
      check("mid_rst_x", int'(x_out), 0);
      check("mid_rst_moving", int'(moving_out), 0);

      // Right-edge bounce: reach x=1210 with vx=+8.
      do_pop(8'h01, 1'b0);
      frames(1);
      halt_level = 1'b1;
      cycle(1'b0);
      halt_level = 1'b0;
      do_pop(8'h07, 1'b0);
      frames(151);
      check("e_x1210", int'(x_out), 1210);
      check("e_y152", int'(y_out), 152);
      frames(1);
      check("e_x_clamp", int'(x_out), 1216);
      frames(1);
      check("e_x_back", int'(x_out), 1208);

      // Corner bounce from x=2, y=3 with vx=-4, vy=-8.
      do_reset();
      do_pop(8'h21, 1'b0);
      frames(1);
      check("f_x2", int'(x_out), 2);
      check("f_y3", int'(y_out), 3);
      halt_level = 1'b1;
      cycle(1'b0);
      halt_level = 1'b0;
      do_pop(8'hFB, 1'b0);
      frames(1);
      check("corner_x", int'(x_out), 0);
      check("corner_y", int'(y_out), 0);
      frames(1);
      check("corner_x_next", int'(x_out), 4);
      check("corner_y_next", int'(y_out), 8);

      // Pop together with nf, then hold the button high for over 100 cycles.
      do_pop(8'h13, 1'b1);
      check("popnf_x", int'(x_out), 4);
      check("popnf_y", int'(y_out), 8);
      check("popnf_pop", int'(pop_out), 1);
      frames(29);
      check("hold29_pop", int'(pop_out), 1);
      frames(1);
      check("hold30_pop", int'(pop_out), 0);
      for (int i = 0; i < 40; i++) cycle(1'b0);
      check("hold_pop_low", int'(pop_out), 0);
      check("hold_moving", int'(moving_out), 1);
      check("hold_x", int'(x_out), 124);
      check("hold_y", int'(y_out), 68);

      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
